// File: rtl/pulp_level_shifter_in_sync.sv
// pulp_level_shifter_in_sync: synchronised, clamped input bank with isolation handshake.
// Define PULP_LEVEL_SHIFTER_GLITCH_FILTER_EN to add a two-sample glitch filter on the data path.
module pulp_level_shifter_in_sync #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter int unsigned      SETTLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] CLAMP_VALUE   = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pwr_ok_i,
    input  logic             iso_req_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic             active_o,
    output logic             iso_ack_o
);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    typedef enum logic [1:0] {ISOLATED, SETTLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] in_q;
    logic [SYNC_STAGES-1:0] pwr_q;
    logic [WIDTH-1:0] sync_d, data;
    logic pwr_ok_s, abort;
    assign sync_d   = in_q[SYNC_STAGES-1];
    assign pwr_ok_s = pwr_q[SYNC_STAGES-1];
    assign abort    = iso_req_i | ~pwr_ok_s;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q  <= '0;
            pwr_q <= '0;
        end else begin
            in_q  <= {in_q[SYNC_STAGES-2:0], in_i};
            pwr_q <= {pwr_q[SYNC_STAGES-2:0], pwr_ok_i};
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ISOLATED;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // Unused encoding falls back to ISOLATED so a captured glitch cannot strand the FSM.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ISOLATED: if (!abort) begin
                state_n = SETTLE;
                cnt_n   = '0;
            end
            SETTLE: if (abort) begin
                state_n = ISOLATED;
                cnt_n   = '0;
            end else begin
                cnt_n   = cnt + CW'(1);
                state_n = (cnt == CW'(SETTLE_CYCLES - 1)) ? ACTIVE : SETTLE;
            end
            ACTIVE:  state_n = abort ? ISOLATED : ACTIVE;
            default: state_n = ISOLATED;
        endcase
    end
`ifdef PULP_LEVEL_SHIFTER_GLITCH_FILTER_EN
    logic [WIDTH-1:0] prev_d, filt_d;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_d <= '0;
            filt_d <= CLAMP_VALUE;
        end else begin
            prev_d <= sync_d;
            filt_d <= (sync_d & ~(sync_d ^ prev_d)) | (filt_d & (sync_d ^ prev_d));
        end
    end
    assign data = filt_d;
`else
    assign data = sync_d;
`endif
    assign out_o     = (state == ACTIVE) ? data : CLAMP_VALUE;
    assign active_o  = (state == ACTIVE);
    assign iso_ack_o = (state == ISOLATED);
endmodule

// File: tb/tb_pulp_level_shifter_in_sync.sv
// tb_pulp_level_shifter_in_sync: directed bench with a cycle-history reference model.
module tb_pulp_level_shifter_in_sync;
    localparam int S  = 2;
    localparam int SC = 4;
    localparam logic [7:0] CL = 8'hA5;
    logic clk = 1'b0;
    logic rst, pwr, iso, act, ack;
    logic [7:0] din, dout;
    int checks = 0;
    int errors = 0;

    pulp_level_shifter_in_sync #(
        .WIDTH(8), .SYNC_STAGES(S), .SETTLE_CYCLES(SC), .CLAMP_VALUE(CL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pwr_ok_i(pwr), .iso_req_i(iso),
        .in_i(din), .out_o(dout), .active_o(act), .iso_ack_o(ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: per-edge input history; a synchronised value is the input sampled
    // S-1 edges earlier, or zero if a reset edge came since then.
    logic [7:0] in_at [0:4095];
    logic       pwr_at [0:4095];
    int cyc = -1;
    int lr = 0;
    int mode = 0;
    int left = 0;
    logic [7:0] filt = CL;
    logic [7:0] a, b, data, exp_out;
    logic exp_act, exp_ack;
    logic mvalid = 1'b0;

    function automatic logic [7:0] sin(int m);
        int j = m - S + 1;
        return (j > lr) ? in_at[j] : 8'h00;
    endfunction

    function automatic logic spw(int m);
        int j = m - S + 1;
        return (j > lr) ? pwr_at[j] : 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        in_at[cyc]  = din;
        pwr_at[cyc] = pwr;
        if (rst) begin
            lr   = cyc;
            mode = 0;
            filt = CL;
        end else begin
            a = sin(cyc - 1);
            b = sin(cyc - 2);
            filt = (~(a ^ b) & a) | ((a ^ b) & filt);
            if (iso || !spw(cyc - 1)) mode = 0;
            else if (mode == 0) begin
                mode = 1;
                left = SC;
            end else if (mode == 1) begin
                left--;
                if (left == 0) mode = 2;
            end
        end
`ifdef PULP_LEVEL_SHIFTER_GLITCH_FILTER_EN
        data = filt;
`else
        data = sin(cyc);
`endif
        exp_out = (mode == 2) ? data : CL;
        exp_act = (mode == 2);
        exp_ack = (mode == 0);
        mvalid  = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_out", dout, exp_out);
            chk("model_active", {7'b0, act}, {7'b0, exp_act});
            chk("model_ack", {7'b0, ack}, {7'b0, exp_ack});
        end
    end

    initial begin
        rst = 1'b1; din = 8'hFF; pwr = 1'b1; iso = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", dout, 8'hA5);
            chk("rst_ack", {7'b0, ack}, 8'h01);
            chk("rst_act", {7'b0, act}, 8'h00);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("pu_e2_ack", {7'b0, ack}, 8'h01);
        @(negedge clk);
        chk("pu_e3_ack", {7'b0, ack}, 8'h00);
        chk("pu_e3_act", {7'b0, act}, 8'h00);
        repeat (3) @(negedge clk);
        chk("pu_e6_act", {7'b0, act}, 8'h00);
        @(negedge clk);
        chk("pu_e7_act", {7'b0, act}, 8'h01);
        chk("pu_e7_out", dout, 8'hFF);
        din = 8'h3C;
        repeat (2) @(negedge clk);
        chk("lat_out", dout, 8'h3C);
        iso = 1'b1;
        @(negedge clk);
        chk("iso_out", dout, 8'hA5);
        chk("iso_ack", {7'b0, ack}, 8'h01);
        chk("iso_act", {7'b0, act}, 8'h00);
        @(negedge clk);
        iso = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_settle_ack", {7'b0, ack}, 8'h00);
        iso = 1'b1;
        @(negedge clk);
        chk("ab_ack", {7'b0, ack}, 8'h01);
        chk("ab_out", dout, 8'hA5);
        iso = 1'b0;
        repeat (4) @(negedge clk);
        chk("ab_resettle_act", {7'b0, act}, 8'h00);
        @(negedge clk);
        chk("ab_active", {7'b0, act}, 8'h01);
        chk("ab_active_out", dout, 8'h3C);
        pwr = 1'b0;
        repeat (2) @(negedge clk);
        chk("pl_still_act", {7'b0, act}, 8'h01);
        @(negedge clk);
        chk("pl_ack", {7'b0, ack}, 8'h01);
        chk("pl_out", dout, 8'hA5);
        for (int i = 1; i < 7; i++) begin
            din = 8'(i * 8'h11);
            @(negedge clk);
            chk("pl_toggle_out", dout, 8'hA5);
        end
        pwr = 1'b1;
        repeat (8) @(negedge clk);
        chk("re_active", {7'b0, act}, 8'h01);
        chk("re_out", dout, 8'h66);
        rst = 1'b1;
        din = 8'h00;
        @(negedge clk);
        chk("mid_rst_ack", {7'b0, ack}, 8'h01);
        chk("mid_rst_out", dout, 8'hA5);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("gl_active", {7'b0, act}, 8'h01);
        chk("gl_base_out", dout, 8'h00);
`ifdef PULP_LEVEL_SHIFTER_GLITCH_FILTER_EN
        din = 8'h01;
        @(negedge clk);
        din = 8'h00;
        repeat (5) begin
            @(negedge clk);
            chk("gl_pulse_blocked", dout, 8'h00);
        end
        din = 8'h01;
        repeat (3) @(negedge clk);
        chk("gl_hold_e3", dout, 8'h00);
        @(negedge clk);
        chk("gl_hold_e4", dout, 8'h01);
`else
        din = 8'h01;
        @(negedge clk);
        din = 8'h00;
        @(negedge clk);
        chk("pulse_visible", dout, 8'h01);
        @(negedge clk);
        chk("pulse_gone", dout, 8'h00);
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
